// File: rtl/back_error_scheduler.sv
// Back-propagation error sequencer. It walks every (node, input) pair of one
// layer, reads the delta and data point RAMs, streams operand pairs into the
// error datapath, and writes the in-order results to the error buffer at
// consecutive linear indices. Completion and fault status go back to the
// training controller.
module back_error_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_NODE     = 32,
    parameter int NUM_INPUT    = 64,
    parameter int PIPE_LATENCY = 14,
    localparam int NW = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1,
    localparam int IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1,
    localparam int WW = (NUM_NODE * NUM_INPUT > 1) ? $clog2(NUM_NODE * NUM_INPUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_hold,
    output logic                  o_rd_en,
    output logic [NW-1:0]         o_delta_addr,
    output logic [IW-1:0]         o_point_addr,
    input  logic [DATA_WIDTH-1:0] i_delta_data,
    input  logic [DATA_WIDTH-1:0] i_point_data,
    output logic                  o_calc_valid,
    output logic [DATA_WIDTH-1:0] o_calc_delta,
    output logic [DATA_WIDTH-1:0] o_calc_point,
    input  logic                  i_calc_valid,
    input  logic [DATA_WIDTH-1:0] i_calc_error,
    output logic                  o_wr_en,
    output logic [WW-1:0]         o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    // Counters one bit wider than the write index so the full pair count fits.
    localparam int CW = WW + 1;
    localparam int TW = $clog2(2 * PIPE_LATENCY + 1);

    localparam logic [NW-1:0] LAST_NODE  = NW'(NUM_NODE - 1);
    localparam logic [IW-1:0] LAST_INPUT = IW'(NUM_INPUT - 1);
    localparam logic [CW-1:0] TOTAL      = CW'(NUM_NODE * NUM_INPUT);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(2 * PIPE_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [NW-1:0] node_cnt;
    logic [IW-1:0] input_cnt;
    logic [CW-1:0] outstanding;   // operand pairs in the datapath, not yet returned
    logic [CW-1:0] wr_cnt;        // writes completed; low bits are the next write index
    logic [TW-1:0] tmo_cnt;       // idle cycles in DRAIN since the last result

    logic active;
    logic last_issue;
    logic result_ok;
    logic result_bad;

    // Results are only meaningful while a pass is in flight; a result with
    // nothing outstanding is a datapath fault and is never written.
    assign active     = (state == ISSUE) || (state == DRAIN);
    assign result_ok  = active && i_calc_valid && (outstanding != '0);
    assign result_bad = active && i_calc_valid && (outstanding == '0);

    assign o_rd_en      = (state == ISSUE) && !i_hold;
    assign o_delta_addr = node_cnt;
    assign o_point_addr = input_cnt;
    assign last_issue   = o_rd_en && (node_cnt == LAST_NODE) && (input_cnt == LAST_INPUT);

    // RAM data is valid the cycle after the read strobe, which is exactly
    // when o_calc_valid is high; outside that window the operands read 0.
    assign o_calc_delta = o_calc_valid ? i_delta_data : '0;
    assign o_calc_point = o_calc_valid ? i_point_data : '0;

    assign o_wr_addr = wr_cnt[WW-1:0];
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);

    // Pass sequencer: issue walk, result collection, outstanding tracking and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            node_cnt     <= '0;
            input_cnt    <= '0;
            outstanding  <= '0;
            wr_cnt       <= '0;
            tmo_cnt      <= '0;
            o_calc_valid <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_data    <= '0;
            o_error      <= 1'b0;
        end else begin
            o_calc_valid <= o_rd_en;
            o_wr_en      <= result_ok;
            if (result_ok) begin
                o_wr_data <= i_calc_error;
            end
            if (o_wr_en) begin
                wr_cnt <= wr_cnt + CW'(1);
            end

            // An issue into the datapath and a returning result cancel out.
            if (o_calc_valid && !result_ok) begin
                outstanding <= outstanding + CW'(1);
            end else if (!o_calc_valid && result_ok) begin
                outstanding <= outstanding - CW'(1);
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state       <= ISSUE;
                        node_cnt    <= '0;
                        input_cnt   <= '0;
                        outstanding <= '0;
                        wr_cnt      <= '0;
                        tmo_cnt     <= '0;
                        o_error     <= 1'b0;
                    end
                end

                ISSUE: begin
                    tmo_cnt <= '0;
                    if (result_bad) begin
                        o_error <= 1'b1;
                    end
                    if (o_rd_en) begin
                        if (input_cnt == LAST_INPUT) begin
                            input_cnt <= '0;
                            node_cnt  <= (node_cnt == LAST_NODE) ? '0 : node_cnt + NW'(1);
                        end else begin
                            input_cnt <= input_cnt + IW'(1);
                        end
                    end
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (result_bad) begin
                        o_error <= 1'b1;
                    end
                    if (i_calc_valid) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != TMO_LIMIT) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                    if (wr_cnt == TOTAL) begin
                        state <= DONE;
                    end else if (!i_calc_valid && (tmo_cnt == TMO_LIMIT) && (outstanding != '0)) begin
                        o_error <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_back_error_scheduler.sv
// Directed bench for back_error_scheduler with a 2x3 layer, registered-read
// RAM models and an ideal 14-cycle datapath model.
module tb_back_error_scheduler;

    localparam int DW = 32;
    localparam int NN = 2;
    localparam int NI = 3;
    localparam int PL = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic          i_hold;
    logic          o_rd_en;
    logic [0:0]    o_delta_addr;
    logic [1:0]    o_point_addr;
    logic [DW-1:0] i_delta_data;
    logic [DW-1:0] i_point_data;
    logic          o_calc_valid;
    logic [DW-1:0] o_calc_delta;
    logic [DW-1:0] o_calc_point;
    logic          i_calc_valid;
    logic [DW-1:0] i_calc_error;
    logic          o_wr_en;
    logic [2:0]    o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    back_error_scheduler #(
        .DATA_WIDTH(DW), .NUM_NODE(NN), .NUM_INPUT(NI), .PIPE_LATENCY(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_hold(i_hold),
        .o_rd_en(o_rd_en), .o_delta_addr(o_delta_addr), .o_point_addr(o_point_addr),
        .i_delta_data(i_delta_data), .i_point_data(i_point_data),
        .o_calc_valid(o_calc_valid), .o_calc_delta(o_calc_delta), .o_calc_point(o_calc_point),
        .i_calc_valid(i_calc_valid), .i_calc_error(i_calc_error),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dval(input int n);
        return 32'h1000_0000 + 32'(n) * 32'h0001_0011;
    endfunction
    function automatic logic [31:0] pval(input int i);
        return 32'h0000_0a00 + 32'(i) * 32'd7;
    endfunction
    function automatic logic [31:0] calc(input logic [31:0] d, input logic [31:0] p);
        return d + (p << 4);
    endfunction
    function automatic logic [31:0] exp_err(input int a);
        return calc(dval(a / NI), pval(a % NI));
    endfunction

    // Registered-read RAMs
    logic [31:0] d_q = '0;
    logic [31:0] p_q = '0;
    int          ra_q = 0;
    always @(posedge clk) begin
        if (o_rd_en) begin
            d_q  <= dval(int'(o_delta_addr));
            p_q  <= pval(int'(o_point_addr));
            ra_q <= int'(o_delta_addr) * NI + int'(o_point_addr);
        end
    end
    assign i_delta_data = d_q;
    assign i_point_data = p_q;

    // Ideal datapath: result appears PL cycles after the operand valid
    bit          drop_en = 1'b0;
    bit          spur    = 1'b0;
    bit          vp [1:PL];
    logic [31:0] dp [1:PL];
    int          ip [1:PL];
    always @(posedge clk) begin
        vp[1] <= o_calc_valid;
        dp[1] <= calc(o_calc_delta, o_calc_point);
        ip[1] <= ra_q;
        for (int s = 2; s <= PL; s++) begin
            vp[s] <= vp[s-1];
            dp[s] <= dp[s-1];
            ip[s] <= ip[s-1];
        end
    end
    assign i_calc_valid = (vp[PL] && !(drop_en && ip[PL] == 4)) || spur;
    assign i_calc_error = dp[PL];

    // Event log sampled on the falling edge
    int          rd_c [256];
    int          rd_na [256];
    int          rd_ia [256];
    int          rd_n = 0;
    int          wr_c [256];
    int          wr_a [256];
    logic [31:0] wr_d [256];
    int          wr_n = 0;
    int          done_c = 0;
    logic        done_e = 1'b0;
    int          done_n = 0;
    int          busy_n = 0;
    always @(negedge clk) begin
        if (o_rd_en && rd_n < 256) begin
            rd_c[rd_n]  <= cyc;
            rd_na[rd_n] <= int'(o_delta_addr);
            rd_ia[rd_n] <= int'(o_point_addr);
            rd_n        <= rd_n + 1;
        end
        if (o_wr_en && wr_n < 256) begin
            wr_c[wr_n] <= cyc;
            wr_a[wr_n] <= int'(o_wr_addr);
            wr_d[wr_n] <= o_wr_data;
            wr_n       <= wr_n + 1;
        end
        if (o_done) begin
            done_c <= cyc;
            done_e <= o_error;
            done_n <= done_n + 1;
        end
        if (o_busy) busy_n <= busy_n + 1;
    end

    int checks = 0;
    int errors = 0;
    int t0, rb, wb, db, bb;

    int rd_norm [6] = '{1, 2, 3, 4, 5, 6};
    int wr_norm [6] = '{17, 18, 19, 20, 21, 22};
    int rd_hold [6] = '{1, 2, 6, 7, 8, 9};
    int wr_hold [6] = '{17, 18, 22, 23, 24, 25};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({o_rd_en, o_delta_addr, o_point_addr, o_calc_valid, o_wr_en,
                                   o_wr_addr, o_busy, o_done, o_error}), 64'd0);
        check({tag, "_data"}, 64'(o_calc_delta | o_calc_point | o_wr_data), 64'd0);
    endtask

    task automatic start_pass();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        t0 = cyc - 1;
        rb = rd_n;
        wb = wr_n;
        db = done_n;
        bb = busy_n;
    endtask

    task automatic goto_cycle(input int k);
        for (int i = 0; i < 200 && (cyc - t0) < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            if (done_n != db) break;
            @(posedge clk);
        end
        #1;
        check("done_seen", 64'(done_n - db), 64'd1);
    endtask

    task automatic check_issues(input int tab [6]);
        check("rd_count", 64'(rd_n - rb), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rd%0d_cycle", k), 64'(rd_c[rb+k] - t0), 64'(tab[k]));
            check($sformatf("rd%0d_node", k), 64'(rd_na[rb+k]), 64'(k / NI));
            check($sformatf("rd%0d_input", k), 64'(rd_ia[rb+k]), 64'(k % NI));
        end
    endtask

    task automatic check_writes(input int tab [6]);
        check("wr_count", 64'(wr_n - wb), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("wr%0d_cycle", k), 64'(wr_c[wb+k] - t0), 64'(tab[k]));
            check($sformatf("wr%0d_addr", k), 64'(wr_a[wb+k]), 64'(k));
            check($sformatf("wr%0d_data", k), 64'(wr_d[wb+k]), 64'(exp_err(k)));
        end
    endtask

    task automatic check_clean_pass(input logic err_exp);
        wait_done(100);
        check_issues(rd_norm);
        check_writes(wr_norm);
        check("done_cycle", 64'(done_c - t0), 64'd24);
        check("done_error", 64'(done_e), 64'(err_exp));
        check("busy_cycles", 64'(busy_n - bb), 64'd24);
        check("idle_after", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int snap;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Plain pass
        start_pass();
        check("busy_c1", 64'(o_busy), 64'd1);
        check_clean_pass(1'b0);

        // Hold during cycles 3..5
        start_pass();
        goto_cycle(3);
        i_hold = 1'b1;
        goto_cycle(6);
        i_hold = 1'b0;
        wait_done(100);
        check_issues(rd_hold);
        check_writes(wr_hold);
        check("hold_done_cycle", 64'(done_c - t0), 64'd27);
        check("hold_done_error", 64'(done_e), 64'd0);

        // Dropped result 4 -> timeout
        repeat (3) @(posedge clk);
        drop_en = 1'b1;
        start_pass();
        wait_done(150);
        drop_en = 1'b0;
        check("drop_wr_count", 64'(wr_n - wb), 64'd5);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drop_wr%0d_data", k), 64'(wr_d[wb+k]), 64'(exp_err(k)));
        end
        check("drop_wr4_data", 64'(wr_d[wb+4]), 64'(exp_err(5)));
        check("drop_done_window", 64'((done_c - t0) >= 50 && (done_c - t0) <= 51), 64'd1);
        check("drop_done_error", 64'(done_e), 64'd1);
        check("drop_busy_low", 64'(o_busy), 64'd0);
        check("drop_error_sticky", 64'(o_error), 64'd1);

        // Next start clears the fault
        start_pass();
        check("start_clears_error", 64'(o_error), 64'd0);
        check_clean_pass(1'b0);

        // Spurious result while idle
        snap = wr_n;
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_spur_no_write", 64'(wr_n - snap), 64'd0);
        check("idle_spur_no_error", 64'(o_error), 64'd0);
        check("idle_spur_idle", 64'(o_busy), 64'd0);

        // Spurious result with nothing outstanding
        start_pass();
        goto_cycle(2);
        spur = 1'b1;
        goto_cycle(3);
        spur = 1'b0;
        check("spur_sets_error", 64'(o_error), 64'd1);
        check_clean_pass(1'b1);

        // Reset in the middle of a pass
        start_pass();
        goto_cycle(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        snap = wr_n;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        db = done_n;
        repeat (30) @(posedge clk);
        #1;
        check("late_no_write", 64'(wr_n - snap), 64'd0);
        check("late_no_done", 64'(done_n - db), 64'd0);
        check("late_idle", 64'(o_busy), 64'd0);

        // Clean pass after reset
        start_pass();
        check_clean_pass(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
